// File: rtl/alu_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract sequencer.
package alu_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int nibbles);
    return $clog2(nibbles);
  endfunction

endpackage

// File: rtl/sum4.sv
// 4-bit ripple-carry adder shared by the serial ALU sequencer.
module sum4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [4:0] carry;

  always_comb begin
    carry    = '0;
    s_o      = '0;
    carry[0] = c_i;
    for (int i = 0; i < 4; i++) begin
      s_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i])
                 | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    c_o = carry[4];
  end

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// W-bit add/subtract sequenced one nibble per clock through one sum4,
// LSB first, with the carry chained through a register.
module nibble_serial_alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sub,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] s,
  output logic                     c_out,
  output logic                     ovf
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int IW = idx_w(NIBBLES);

  state_t           state_q, state_d;
  logic [W-1:0]     ra_q, rb_q, s_q;
  logic [IW-1:0]    idx_q;
  logic             cy_q, cout_q, ovf_q;

  logic [NIB_W-1:0] nib_a, nib_b, sum;
  logic             co;
  logic             accept, run, last;

  assign run    = (state_q == RUN);
  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign last   = (idx_q == IW'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Nibble select for the shared adder
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        nib_a = ra_q[i*NIB_W +: NIB_W];
        nib_b = rb_q[i*NIB_W +: NIB_W];
      end
    end
  end

  sum4 u_sum4 (
    .a_i (nib_a),
    .b_i (nib_b),
    .c_i (cy_q),
    .s_o (sum),
    .c_o (co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_q   <= '0;
      rb_q   <= '0;
      s_q    <= '0;
      idx_q  <= '0;
      cy_q   <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      ra_q   <= a;
      rb_q   <= sub ? ~b : b;
      cy_q   <= sub;
      idx_q  <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (run) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx_q == IW'(i))
          s_q[i*NIB_W +: NIB_W] <= sum;
      end
      cy_q  <= co;
      idx_q <= idx_q + 1'b1;
      if (last) begin
        cout_q <= co;
        // Same-sign operands whose result sign differs
        ovf_q  <= (ra_q[W-1] ~^ rb_q[W-1])
                & (sum[NIB_W-1] ^ ra_q[W-1]);
      end
    end
  end

  assign s     = s_q;
  assign c_out = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Directed and random checks of nibble_serial_alu_ctrl against an
// integer-arithmetic reference model.
module tb_nibble_serial_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] s;
  logic        c_out, ovf;

  int checks = 0;
  int errors = 0;

  logic [15:0] ma, mb;
  logic        msub;
  logic [17:0] last_r;

  nibble_serial_alu_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c_out (c_out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, c_out, s} from plain integer arithmetic
  function automatic logic [17:0] model(input logic [15:0] x,
                                       input logic [15:0] y,
                                       input logic        op);
    int ux, uy, sx, sy, ru, rs;
    logic c, o;
    logic [15:0] r;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (op) begin
      ru = ux - uy;
      rs = sx - sy;
      c  = (ux >= uy);
    end else begin
      ru = ux + uy;
      rs = sx + sy;
      c  = (ru > 65535);
    end
    r = ru[15:0];
    o = (rs > 32767) || (rs < -32768);
    return {o, c, r};
  endfunction

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                       input logic isub);
    a     = ia;
    b     = ib;
    sub   = isub;
    start = 1'b1;
    ma    = ia;
    mb    = ib;
    msub  = isub;
  endtask

  // Called at the negedge in which start is high; returns at the
  // negedge of the done cycle.
  task automatic finish(input string tag, input bit poke);
    int cyc, bc;
    logic [17:0] e;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    cyc = 1;
    bc  = 0;
    while (!done && cyc < 20) begin
      if (busy) bc++;
      if (poke && cyc == 2) begin
        start = 1'b1;
        a     = 16'($urandom);
        b     = 16'($urandom);
        sub   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    e = model(ma, mb, msub);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'd5);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'd4);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, "_s"}, 32'(s), 32'(e[15:0]));
    chk({tag, "_c_out"}, 32'(c_out), 32'(e[16]));
    chk({tag, "_ovf"}, 32'(ovf), 32'(e[17]));
    last_r = {ovf, c_out, s};
  endtask

  task automatic op(input string tag, input logic [15:0] ia,
                    input logic [15:0] ib, input logic isub);
    @(negedge clk);
    issue(ia, ib, isub);
    finish(tag, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", 32'({c_out, ovf}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op("add1", 16'h1234, 16'h0FFF, 1'b0);
    chk("add1_k", 32'(last_r), 32'h0_2233);
    op("carry", 16'hFFFF, 16'h0001, 1'b0);
    chk("carry_k", 32'(last_r), 32'h1_0000);
    op("povf", 16'h7FFF, 16'h0001, 1'b0);
    chk("povf_k", 32'(last_r), 32'h2_8000);
    op("sub1", 16'h0005, 16'h0007, 1'b1);
    chk("sub1_k", 32'(last_r), 32'h0_FFFE);
    op("subovf", 16'h8000, 16'h0001, 1'b1);
    chk("subovf_k", 32'(last_r), 32'h3_7FFF);

    // Start pulse during RUN must be ignored
    @(negedge clk);
    issue(16'h1234, 16'h0FFF, 1'b0);
    finish("ignore", 1'b1);
    chk("ignore_k", 32'(last_r), 32'h0_2233);

    // Back-to-back: new start in the DONE cycle
    @(negedge clk);
    issue(16'hABCD, 16'h1111, 1'b1);
    finish("b2b_first", 1'b0);
    issue(16'h0001, 16'h0001, 1'b0);
    finish("b2b_second", 1'b0);
    chk("b2b_k", 32'(last_r), 32'h0_0002);

    // Reset mid-RUN after nibble 1 committed
    @(negedge clk);
    issue(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_s", 32'(s), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mrst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    op("post_rst", 16'h00F0, 16'h0F10, 1'b0);

    for (int i = 0; i < 20; i++) begin
      op("rand", 16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
